// File: rtl/decode_ctrl_stage_pkg.sv
// Shared RV32I(+M) decode definitions: opcodes, ALU/WB/MEM codes,
// and the control bundle carried in the ID/EX register.
package decode_ctrl_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SLL    = 5'b00001;
  localparam logic [4:0] ALU_SLT    = 5'b00010;
  localparam logic [4:0] ALU_SLTU   = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_AND    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_NONE   = 5'b01001;
  localparam logic [4:0] ALU_SRA    = 5'b01101;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] WB_MEM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  typedef struct packed {
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic [1:0] wbctrl;
    logic [4:0] aluop;
    logic       alus1;
    logic       alus2;
    logic [2:0] brctrl;
    logic [2:0] memctrl;
    logic       dojump;
    logic       dobranch;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_ex_t;

  localparam ctrl_t CTRL_NOP = '{
    regwr: 1'b0, memrd: 1'b0, memwr: 1'b0,
    wbctrl: WB_NONE, aluop: ALU_NONE,
    alus1: 1'b0, alus2: 1'b0,
    brctrl: 3'b000, memctrl: 3'b000,
    dojump: 1'b0, dobranch: 1'b0
  };

  localparam id_ex_t ID_EX_RST = '{
    ctrl: CTRL_NOP, illegal: 1'b0,
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0
  };

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Instruction-in / ID/EX-out handshake bundle of the decode stage.
interface decode_ctrl_stage_if;
  import decode_ctrl_stage_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        regWR;
  logic        memRD;
  logic        memWR;
  logic [1:0]  wbCtrl;
  logic [4:0]  aluOp;
  logic        aluS1;
  logic        aluS2;
  logic [2:0]  branchCtrl;
  logic [2:0]  memCtrl;
  logic        doJump;
  logic        doBranch;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid,
    input  regWR, memRD, memWR, wbCtrl, aluOp,
    input  aluS1, aluS2, branchCtrl, memCtrl,
    input  doJump, doBranch, rd, rs1, rs2, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid,
    output regWR, memRD, memWR, wbCtrl, aluOp,
    output aluS1, aluS2, branchCtrl, memCtrl,
    output doJump, doBranch, rd, rs1, rs2, illegal
  );
endinterface

// File: rtl/decode_ctrl_stage_rv_decode.sv
// Combinational RV32I(+M) decoder: instruction word to ID/EX entry,
// plus which source registers the instruction actually reads.
module rv_decode
  import decode_ctrl_stage_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [31:0] instr,
  output id_ex_t      ent,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       bad;
  ctrl_t      c;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    c   = CTRL_NOP;
    bad = 1'b0;
    unique case (1'b1)
      op == OPC_OP: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_ALU;
        c.alus1  = 1'b1;
        c.alus2  = 1'b1;
        if (f7 == 7'b0000000)
          c.aluop = {2'b00, f3};
        else if (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          c.aluop = {2'b01, f3};
        else if (f7 == 7'b0000001 && EN_MEXT)
          c.aluop = {2'b10, f3};
        else
          bad = 1'b1;
      end
      op == OPC_IMM: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_ALU;
        c.alus1  = 1'b1;
        c.aluop  = {2'b00, f3};
        if (f3 == 3'b001 && f7 != 7'b0000000)
          bad = 1'b1;
        else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)
            c.aluop = {2'b01, f3};
          else if (f7 != 7'b0000000)
            bad = 1'b1;
        end
      end
      op == OPC_LOAD: begin
        c.regwr  = 1'b1;
        c.memrd  = 1'b1;
        c.wbctrl = WB_MEM;
        c.alus1  = 1'b1;
        c.aluop  = ALU_ADD;
        case (f3)
          3'b000:  c.memctrl = MEM_LB;
          3'b001:  c.memctrl = MEM_LH;
          3'b010:  c.memctrl = MEM_LW;
          3'b100:  c.memctrl = MEM_LBU;
          3'b101:  c.memctrl = MEM_LHU;
          default: bad = 1'b1;
        endcase
      end
      op == OPC_STORE: begin
        c.memwr = 1'b1;
        c.alus1 = 1'b1;
        c.aluop = ALU_ADD;
        case (f3)
          3'b000:  c.memctrl = MEM_SB;
          3'b001:  c.memctrl = MEM_SH;
          3'b010:  c.memctrl = MEM_SW;
          default: bad = 1'b1;
        endcase
      end
      op == OPC_BRANCH: begin
        c.dobranch = 1'b1;
        c.brctrl   = f3;
        c.alus1    = 1'b1;
        c.alus2    = 1'b1;
        c.aluop    = ALU_SUB;
        if (f3 == 3'b010 || f3 == 3'b011)
          bad = 1'b1;
      end
      op == OPC_LUI: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_ALU;
        c.aluop  = ALU_ADD;
        c.alus1  = 1'b1;
      end
      op == OPC_AUIPC: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_ALU;
        c.aluop  = ALU_ADD;
      end
      op == OPC_JAL: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_PC4;
        c.dojump = 1'b1;
      end
      op == OPC_JALR: begin
        c.regwr  = 1'b1;
        c.wbctrl = WB_PC4;
        c.dojump = 1'b1;
        c.alus1  = 1'b1;
        if (f3 != 3'b000)
          bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad)
      c = CTRL_NOP;
  end

  // LUI adds to x0, so its rs1 field is forced to zero
  always_comb begin
    ent.ctrl    = c;
    ent.illegal = bad;
    ent.rd      = instr[11:7];
    ent.rs1     = (op == OPC_LUI) ? 5'd0 : instr[19:15];
    ent.rs2     = instr[24:20];
  end

  assign uses_rs1 = !(op == OPC_LUI || op == OPC_AUIPC ||
                      op == OPC_JAL);
  assign uses_rs2 = (op == OPC_OP || op == OPC_STORE ||
                     op == OPC_BRANCH);

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: ID/EX register with valid/ready handshake,
// load-use bubble insertion, flush, and a saturating bubble counter.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter bit EN_MEXT       = 1'b1,
  parameter bit LOADUSE_STALL = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_ctrl_stage_if.slave bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  id_ex_t q;
  id_ex_t d;
  logic   q_valid;
  logic   uses_rs1;
  logic   uses_rs2;
  logic   hit1;
  logic   hit2;
  logic   haz;
  logic   load;

  rv_decode #(.EN_MEXT(EN_MEXT)) u_dec (
    .instr    (bus.instr),
    .ent      (d),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign hit1 = uses_rs1 && (bus.instr[19:15] == q.rd);
  assign hit2 = uses_rs2 && (bus.instr[24:20] == q.rd);
  assign haz  = LOADUSE_STALL && q_valid && q.ctrl.memrd &&
                (q.rd != 5'd0) && bus.in_valid && (hit1 || hit2);

  assign bus.in_ready = (!q_valid || bus.out_ready) &&
                        !haz && !flush;
  assign load = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid    <= 1'b0;
      q          <= ID_EX_RST;
      bubble_cnt <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q       <= d;
    end else if (bus.out_ready) begin
      q_valid <= 1'b0;
      // the load drains while the dependent instr waits: one bubble
      if (haz && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.out_valid  = q_valid;
  assign bus.regWR      = q.ctrl.regwr;
  assign bus.memRD      = q.ctrl.memrd;
  assign bus.memWR      = q.ctrl.memwr;
  assign bus.wbCtrl     = q.ctrl.wbctrl;
  assign bus.aluOp      = q.ctrl.aluop;
  assign bus.aluS1      = q.ctrl.alus1;
  assign bus.aluS2      = q.ctrl.alus2;
  assign bus.branchCtrl = q.ctrl.brctrl;
  assign bus.memCtrl    = q.ctrl.memctrl;
  assign bus.doJump     = q.ctrl.dojump;
  assign bus.doBranch   = q.ctrl.dobranch;
  assign bus.rd         = q.rd;
  assign bus.rs1        = q.rs1;
  assign bus.rs2        = q.rs2;
  assign bus.illegal    = q.illegal;

endmodule
